mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_arb_rr2.sv | 25 ++
 rtl/mem_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter.
// Holds the FSM and owner encodings and the default abort timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int         TIMEOUT_CYCLES_DEF = 1024;
  localparam int         DATA_W             = 32;
  localparam logic [3:0] BE_ALL             = 4'hF;

endpackage

// File: rtl/mem_arb_arb_rr2.sv
// Two-way round-robin decision between the fetch and load/store requesters.
// When both ask, the requester that did not own the last transaction wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   req_if,
  input  logic   req_ls,
  input  owner_e last_owner,
  output logic   gnt_if,
  output logic   gnt_ls
);

  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (req_if && req_ls) begin
      gnt_ls = (last_owner == OWN_IF);
      gnt_if = (last_owner == OWN_LS);
    end else begin
      gnt_if = req_if;
      gnt_ls = req_ls;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one memory port between instruction fetch and load/store,
// with a single outstanding transaction and a cycle-count abort.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_be,
  input  logic [DATA_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_e            state, state_nx;
  owner_e            last_owner, owner_p1;
  logic [DATA_W-1:0] addr_p1, wdata_p1;
  logic [3:0]        be_p1;
  logic              we_p1;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic gnt_if_w, gnt_ls_w, arb_en, granted;
  logic tmo, done_ok, fire;

  // Grants exist only in IDLE and never while reset holds the block.
  assign arb_en  = rst && (state == ST_IDLE);
  assign granted = gnt_if_w || gnt_ls_w;

  arb_rr2 u_arb (
    .req_if     (if_req && arb_en),
    .req_ls     (ls_req && arb_en),
    .last_owner (last_owner),
    .gnt_if     (gnt_if_w),
    .gnt_ls     (gnt_ls_w)
  );

  // A response arriving in the last allowed RSP cycle still wins over the abort.
  assign tmo     = (state != ST_IDLE) && (cnt == TMO_LAST) &&
                   !((state == ST_RSP) && mem_rvalid);
  assign done_ok = !tmo && (((state == ST_RSP) && mem_rvalid) ||
                            ((state == ST_REQ) && mem_gnt && mem_rvalid));
  assign fire    = done_ok || tmo;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (granted) begin
          state_nx = ST_REQ;
          cnt_nx   = '0;
        end
      end
      ST_REQ: begin
        cnt_nx = sat_inc(cnt);
        if (tmo)          state_nx = ST_IDLE;
        else if (mem_gnt) state_nx = mem_rvalid ? ST_IDLE : ST_RSP;
      end
      ST_RSP: begin
        cnt_nx = sat_inc(cnt);
        if (fire) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Stage p1: request captured at grant, held until the transaction ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_owner <= OWN_IF;
      owner_p1   <= OWN_IF;
      cnt        <= '0;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      be_p1      <= '0;
      we_p1      <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (granted) begin
        owner_p1   <= gnt_ls_w ? OWN_LS : OWN_IF;
        last_owner <= gnt_ls_w ? OWN_LS : OWN_IF;
        addr_p1    <= gnt_ls_w ? ls_addr : if_addr;
        wdata_p1   <= gnt_ls_w ? ls_wdata : '0;
        be_p1      <= gnt_ls_w ? ls_be : BE_ALL;
        we_p1      <= gnt_ls_w && ls_we;
      end
    end
  end

  assign if_gnt    = gnt_if_w;
  assign ls_gnt    = gnt_ls_w;

  assign mem_req   = (state == ST_REQ) && !tmo;
  assign mem_we    = mem_req && we_p1;
  assign mem_be    = mem_req ? be_p1 : 4'h0;
  assign mem_addr  = mem_req ? addr_p1 : '0;
  assign mem_wdata = mem_req ? wdata_p1 : '0;

  assign if_rvalid = fire && (owner_p1 == OWN_IF);
  assign ls_rvalid = fire && (owner_p1 == OWN_LS);
  assign if_err    = tmo && (owner_p1 == OWN_IF);
  assign ls_err    = tmo && (owner_p1 == OWN_LS);
  assign if_rdata  = (done_ok && (owner_p1 == OWN_IF)) ? mem_rdata : '0;
  assign ls_rdata  = (done_ok && (owner_p1 == OWN_LS)) ? mem_rdata : '0;

endmodule
